// File: rtl/dircc_node_msg_rx_writer.sv
// Receive-side writer: deposits incoming Avalon-ST packets into a ring of
// fixed-size message slots over the s2 memory port and tracks filled slots.
module dircc_node_msg_rx_writer #(
    parameter logic [13:0] BASE_ADDR = 14'd8000,
    parameter int unsigned SLOT_HW   = 32,
    parameter int unsigned NUM_SLOTS = 4
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic [15:0]                    sink_data,
    input  logic                           sink_valid,
    input  logic                           sink_startofpacket,
    input  logic                           sink_endofpacket,
    output logic                           sink_ready,
    output logic [13:0]                    address2,
    output logic [15:0]                    writedata2,
    output logic [1:0]                     byteenable2,
    output logic                           chipselect2,
    output logic                           write2,
    output logic                           clken2,
    input  logic                           rx_ack,
    output logic [$clog2(NUM_SLOTS+1)-1:0] rx_pending,
    output logic                           rx_irq,
    output logic [7:0]                     drop_count
);

    localparam int unsigned PW    = $clog2(NUM_SLOTS + 1);
    localparam int unsigned SW    = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam int unsigned IW    = $clog2(SLOT_HW) + 1;
    localparam int unsigned SHIFT = $clog2(SLOT_HW);

    typedef enum logic [1:0] {IDLE, DATA, DRAIN, HDR} state_e;

    state_e         state_q, state_d;
    logic [SW-1:0]  wr_slot_q, wr_slot_d, rd_slot_q, rd_slot_d;
    logic [PW-1:0]  pending_q, pending_d;
    logic [IW-1:0]  idx_q, idx_d;
    logic [14:0]    len_q, len_d;
    logic           trunc_q, trunc_d;
    logic [7:0]     drop_q, drop_d;
    logic           commit_q, commit_d;
    logic           irq_q;
    logic           run_q;
    logic           we_q, we_d;
    logic [13:0]    addr_q, addr_d;
    logic [15:0]    wdata_q, wdata_d;
    logic           accept;
    logic           ack_ok;
    logic [13:0]    slot_base;

    assign slot_base = BASE_ADDR + (14'(wr_slot_q) << SHIFT);

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept && sink_startofpacket)
                      state_d = sink_endofpacket ? HDR : DATA;
            DATA: if (accept) begin
                      if (sink_endofpacket)            state_d = HDR;
                      else if (idx_q == IW'(SLOT_HW))  state_d = DRAIN;
                  end
            DRAIN: if (accept && sink_endofpacket) state_d = HDR;
            HDR:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output and datapath next values; ready stays low while a commit is in flight
    always_comb begin
        sink_ready = 1'b0;
        we_d       = 1'b0;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        idx_d      = idx_q;
        len_d      = len_q;
        trunc_d    = trunc_q;
        drop_d     = drop_q;
        wr_slot_d  = wr_slot_q;
        commit_d   = 1'b0;
        case (state_q)
            IDLE:        sink_ready = run_q & ~commit_q & (pending_q < PW'(NUM_SLOTS));
            DATA, DRAIN: sink_ready = 1'b1;
            default:     sink_ready = 1'b0;
        endcase
        accept = sink_valid & sink_ready;
        case (state_q)
            IDLE: if (accept) begin
                if (sink_startofpacket) begin
                    we_d    = 1'b1;
                    addr_d  = slot_base + 14'd1;
                    wdata_d = sink_data;
                    len_d   = 15'd1;
                    idx_d   = IW'(2);
                    trunc_d = 1'b0;
                end else if (drop_q != 8'hFF) begin
                    drop_d = drop_q + 8'd1;
                end
            end
            DATA: if (accept) begin
                if (idx_q < IW'(SLOT_HW)) begin
                    we_d    = 1'b1;
                    addr_d  = slot_base + 14'(idx_q);
                    wdata_d = sink_data;
                    idx_d   = idx_q + IW'(1);
                    len_d   = len_q + 15'd1;
                end else begin
                    trunc_d = 1'b1;
                end
            end
            HDR: begin
                we_d      = 1'b1;
                addr_d    = slot_base;
                wdata_d   = {trunc_q, len_q};
                commit_d  = 1'b1;
                wr_slot_d = (wr_slot_q == SW'(NUM_SLOTS - 1)) ? '0 : wr_slot_q + SW'(1);
            end
            default: ;
        endcase
    end

    // Slot occupancy: commit and ack in the same cycle cancel out
    always_comb begin
        ack_ok    = rx_ack && (pending_q != '0);
        pending_d = pending_q;
        rd_slot_d = rd_slot_q;
        if (commit_q && !ack_ok)      pending_d = pending_q + PW'(1);
        else if (!commit_q && ack_ok) pending_d = pending_q - PW'(1);
        if (ack_ok)
            rd_slot_d = (rd_slot_q == SW'(NUM_SLOTS - 1)) ? '0 : rd_slot_q + SW'(1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_slot_q <= '0;
            rd_slot_q <= '0;
            pending_q <= '0;
            idx_q     <= '0;
            len_q     <= '0;
            trunc_q   <= 1'b0;
            drop_q    <= '0;
            commit_q  <= 1'b0;
            irq_q     <= 1'b0;
            run_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
        end else begin
            wr_slot_q <= wr_slot_d;
            rd_slot_q <= rd_slot_d;
            pending_q <= pending_d;
            idx_q     <= idx_d;
            len_q     <= len_d;
            trunc_q   <= trunc_d;
            drop_q    <= drop_d;
            commit_q  <= commit_d;
            irq_q     <= (pending_d != '0);
            run_q     <= 1'b1;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
        end
    end

    assign address2    = addr_q;
    assign writedata2  = wdata_q;
    assign byteenable2 = 2'b11;
    assign chipselect2 = we_q;
    assign write2      = we_q;
    assign clken2      = run_q;
    assign rx_pending  = pending_q;
    assign rx_irq      = irq_q;
    assign drop_count  = drop_q;

endmodule
